// File: rtl/tone_dac_driver.sv
// Square-wave tone synthesiser feeding a left-justified 16-bit stereo audio DAC.
// One free-running frame counter derives every DAC clock; all pins are registered.
module tone_dac_driver #(
  parameter logic [15:0] AMPLITUDE = 16'h2000,
  parameter int          DIV_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] note_div,
  input  logic             mute,
  output logic             audio_mclk,
  output logic             audio_sck,
  output logic             audio_lrck,
  output logic             audio_sdin
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_TWO = {{(DIV_W-2){1'b0}}, 2'b10};

  logic [9:0]       fcnt_r;
  logic [DIV_W-1:0] note_q_r;
  logic [DIV_W-1:0] tcnt_r;
  logic             phase_r;
  logic [15:0]      shreg_r;

  logic [DIV_W-1:0] half_s;
  logic             silent_s;
  logic             tone_end_s;
  logic             frame_start_s;
  logic [15:0]      sample_s;
  logic [15:0]      word_s;
  logic             sdin_next_s;

  // Tone bookkeeping, sample selection and the next serial bit.
  always_comb begin
    half_s        = {1'b0, note_q_r[DIV_W-1:1]};
    silent_s      = (note_q_r < DIV_TWO);
    tone_end_s    = (tcnt_r == (half_s - DIV_ONE));
    frame_start_s = (fcnt_r[8:0] == 9'd0);

    if (mute || silent_s) begin
      sample_s = 16'h0000;
    end else if (phase_r) begin
      sample_s = AMPLITUDE;
    end else begin
      sample_s = 16'h0000 - AMPLITUDE;
    end

    // At the half-frame boundary the fresh sample bypasses the shift register.
    if (frame_start_s) begin
      word_s = sample_s;
    end else begin
      word_s = shreg_r;
    end

    // Slots 0..15 carry bits 15..0; the upper half of the half-frame is padding.
    if (fcnt_r[8]) begin
      sdin_next_s = 1'b0;
    end else begin
      sdin_next_s = word_s[~fcnt_r[7:4]];
    end
  end

  // Frame counter and registered DAC pins, all lagging fcnt by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_r     <= 10'd0;
      audio_mclk <= 1'b0;
      audio_sck  <= 1'b0;
      audio_lrck <= 1'b0;
      audio_sdin <= 1'b0;
    end else begin
      fcnt_r     <= fcnt_r + 10'd1;
      audio_mclk <= fcnt_r[1];
      audio_sck  <= fcnt_r[3];
      audio_lrck <= fcnt_r[9];
      audio_sdin <= sdin_next_s;
    end
  end

  // Word latch: the sample is frozen for the whole half-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= 16'h0000;
    end else if (frame_start_s) begin
      shreg_r <= sample_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Tone generator; a new note restarts at the low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q_r <= {DIV_W{1'b0}};
      tcnt_r   <= {DIV_W{1'b0}};
      phase_r  <= 1'b0;
    end else if (note_div != note_q_r) begin
      note_q_r <= note_div;
      tcnt_r   <= {DIV_W{1'b0}};
      phase_r  <= 1'b0;
    end else if (silent_s) begin
      tcnt_r   <= {DIV_W{1'b0}};
      phase_r  <= 1'b0;
    end else if (tone_end_s) begin
      tcnt_r   <= {DIV_W{1'b0}};
      phase_r  <= ~phase_r;
    end else begin
      tcnt_r   <= tcnt_r + DIV_ONE;
    end
  end

endmodule

// File: tb/tb_tone_dac_driver.sv
// Directed testbench for tone_dac_driver: DAC clocking, tone phase timing,
// captured serial words, mute windows, note changes and asynchronous reset.
module tb_tone_dac_driver;

  logic        clk;
  logic        rst_n;
  logic [19:0] note_div;
  logic        mute;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;

  int checks;
  int errors;

  tone_dac_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_div   (note_div),
    .mute       (mute),
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits (bounded) for the frame counter to reach a value, seen at a negedge.
  task automatic wait_fcnt(input logic [9:0] target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (dut.fcnt_r !== target && guard < 2048);
    checks++;
    if (dut.fcnt_r !== target) begin
      errors++;
      $display("FAIL wait_fcnt: fcnt=%0d, required %0d", dut.fcnt_r, target);
    end
  endtask

  // Collects one half-frame word from the pins, starting at the next lrck change.
  task automatic capture_word(output logic [15:0] w, output logic tail, output logic ok);
    logic lr0;
    logic sck0;
    int   n;
    int   guard;
    w = 16'h0000; tail = 1'b0; ok = 1'b1;
    lr0 = audio_lrck; guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (audio_lrck == lr0 && guard < 1100);
    if (audio_lrck == lr0) begin
      ok = 1'b0;
      return;
    end
    sck0 = audio_sck; n = 0; guard = 0;
    while (n < 32 && guard < 600) begin
      @(negedge clk);
      guard++;
      if (audio_sck && !sck0) begin
        if (n < 16) w = {w[14:0], audio_sdin};
        else        tail = tail | audio_sdin;
        n++;
      end
      sck0 = audio_sck;
    end
    if (n < 32) ok = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; note_div = 20'd0; mute = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000",
               {audio_mclk, audio_sck, audio_lrck, audio_sdin});
    end
    checks++;
    if (dut.fcnt_r !== 10'd0) begin
      errors++;
      $display("FAIL reset_fcnt: got %0d, required 0", dut.fcnt_r);
    end
  endtask

  task automatic test_clocks;
    int m1, m2, s1, s2, l1, l2, ones;
    logic pm, ps, pl;
    m1 = 0; m2 = 0; s1 = 0; s2 = 0; l1 = 0; l2 = 0; ones = 0;
    pm = 1'b0; ps = 1'b0; pl = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      @(negedge clk);
      if (audio_mclk && !pm) begin if (m1 == 0) m1 = k; else if (m2 == 0) m2 = k; end
      if (audio_sck  && !ps) begin if (s1 == 0) s1 = k; else if (s2 == 0) s2 = k; end
      if (audio_lrck && !pl) begin if (l1 == 0) l1 = k; else if (l2 == 0) l2 = k; end
      if (audio_sdin) ones++;
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    end
    checks++;
    if (m2 - m1 != 4) begin errors++; $display("FAIL mclk_period: got %0d, required 4", m2 - m1); end
    checks++;
    if (m1 != 3) begin errors++; $display("FAIL mclk_first_rise: got %0d, required 3", m1); end
    checks++;
    if (s2 - s1 != 16) begin errors++; $display("FAIL sck_period: got %0d, required 16", s2 - s1); end
    checks++;
    if (s1 != 9) begin errors++; $display("FAIL sck_first_rise: got %0d, required 9", s1); end
    checks++;
    if (l2 - l1 != 1024) begin errors++; $display("FAIL lrck_period: got %0d, required 1024", l2 - l1); end
    // fcnt reaches 512 at edge 512; the registered pin shows it one edge later.
    checks++;
    if (l1 != 513) begin errors++; $display("FAIL lrck_first_rise: got %0d, required 513", l1); end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL silent_sdin: got %0d high samples, required 0", ones); end
  endtask

  task automatic test_mute;
    logic [15:0] w;
    logic        tail;
    logic        ok;
    logic [15:0] exp_w [6];
    exp_w = '{16'hE000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hE000};
    @(negedge clk);
    note_div = 20'd76628;
    wait_fcnt(10'd600);
    wait_fcnt(10'd1023);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          capture_word(w, tail, ok);
          checks++;
          if (ok !== 1'b1 || w !== exp_w[i] || tail !== 1'b0) begin
            errors++;
            $display("FAIL mute_word%0d: got %h tail %b ok %b, required %h tail 0 ok 1",
                     i, w, tail, ok, exp_w[i]);
          end
        end
      end
      begin
        repeat (101) @(negedge clk);
        mute = 1'b1;
        repeat (2000) @(negedge clk);
        mute = 1'b0;
      end
    join
  endtask

  task automatic test_odd_and_silence;
    logic [15:0] w;
    logic        tail;
    logic        ok;
    int          bad;
    @(negedge clk);
    note_div = 20'd5;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] kv;
      kv = 4'(k);
      @(negedge clk);
      checks++;
      if (dut.phase_r !== kv[1]) begin
        errors++;
        $display("FAIL odd_phase_k%0d: got %b, required %b", k, dut.phase_r, kv[1]);
      end
    end
    note_div = 20'd1;
    capture_word(w, tail, ok);
    capture_word(w, tail, ok);
    checks++;
    if (ok !== 1'b1 || w !== 16'h0000) begin
      errors++;
      $display("FAIL silence_word: got %h ok %b, required 0000 ok 1", w, ok);
    end
    bad = 0;
    fork
      begin
        for (int i = 0; i < 2200; i++) begin
          note_div = (i % 2 == 0) ? 20'd6 : 20'd7;
          @(negedge clk);
          if (dut.phase_r !== 1'b0) bad++;
        end
      end
      begin
        capture_word(w, tail, ok);
        for (int i = 0; i < 2; i++) begin
          capture_word(w, tail, ok);
          checks++;
          if (ok !== 1'b1 || w !== 16'hE000) begin
            errors++;
            $display("FAIL churn_word%0d: got %h ok %b, required E000 ok 1", i, w, ok);
          end
        end
      end
    join
    checks++;
    if (bad != 0) begin errors++; $display("FAIL churn_phase: got %0d nonzero cycles, required 0", bad); end
  endtask

  task automatic test_tone_and_switch;
    logic [15:0] w;
    logic        tail;
    logic        ok;
    int          f, d0, exp_e, c, tails, fails;
    @(negedge clk);
    note_div = 20'd76628;
    f = int'(dut.fcnt_r);
    // Words latched at edges 1..38314 after the load see the low phase.
    d0 = (512 - (f % 512)) % 512;
    if (d0 == 0) d0 = 512;
    exp_e = (38314 - d0) / 512 + 1;
    c = 0; tails = 0; fails = 0;
    fork
      begin
        do begin
          @(negedge clk);
          c++;
        end while (dut.phase_r !== 1'b1 && c < 40000);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 77; i++) begin
          capture_word(w, tail, ok);
          if (ok !== 1'b1) fails++;
          if (tail) tails++;
          checks++;
          if (w !== ((i < exp_e) ? 16'hE000 : 16'h2000)) begin
            errors++;
            $display("FAIL tone_word%0d: got %h, required %h", i, w,
                     (i < exp_e) ? 16'hE000 : 16'h2000);
          end
        end
      end
    join
    checks++;
    if (c != 38315) begin errors++; $display("FAIL tone_half_period: got %0d, required 38315", c); end
    checks++;
    if (tails != 0 || fails != 0) begin
      errors++;
      $display("FAIL tone_tail: got %0d nonzero tails %0d timeouts, required 0 0", tails, fails);
    end
    note_div = 20'd40485;
    @(negedge clk);
    checks++;
    if (dut.tcnt_r !== 20'd0 || dut.phase_r !== 1'b0) begin
      errors++;
      $display("FAIL switch_restart: got tcnt %0d phase %b, required 0 0", dut.tcnt_r, dut.phase_r);
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (dut.phase_r !== 1'b1 && c < 25000);
    checks++;
    if (c != 20242) begin errors++; $display("FAIL switch_toggle: got %0d, required 20242", c); end
  endtask

  task automatic test_reset_mid_word;
    logic [3:0] pins;
    int         k;
    wait_fcnt(10'd300);
    pins = {audio_mclk, audio_sck, audio_lrck, audio_sdin};
    checks++;
    if (pins !== 4'b1100) begin errors++; $display("FAIL pre_reset_pins: got %b, required 1100", pins); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b, required 0000",
               {audio_mclk, audio_sck, audio_lrck, audio_sdin});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (audio_lrck !== 1'b1 && k < 1100);
    checks++;
    if (k != 513) begin errors++; $display("FAIL post_reset_lrck: got %0d, required 513", k); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clocks();
    test_mute();
    test_odd_and_silence();
    test_tone_and_switch();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
